// File: rtl/reg_bank_multi.sv
// reg_bank_multi: byte-enabled register bank with two registered read ports,
// write-first forwarding, synchronous clear and saturating error counting.
//
// Ports:
//   clk, rst                        clock, async active-high reset
//   wr_en, wr_addr, wr_data, wr_be  byte-lane write request
//   clr                             synchronous clear of all registers
//   rd_en_a/b, rd_addr_a/b          read requests, ports A and B
//   rd_data_a/b, rd_valid_a/b       registered read data and fresh-data pulse
//   err, err_cnt                    invalid-access pulse and saturating count
module reg_bank_multi #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 4,
    parameter int NUM_REGS = 14
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic [DATA_W/8-1:0] wr_be,
    input  logic                clr,
    input  logic                rd_en_a,
    input  logic [ADDR_W-1:0]   rd_addr_a,
    input  logic                rd_en_b,
    input  logic [ADDR_W-1:0]   rd_addr_b,
    output logic [DATA_W-1:0]   rd_data_a,
    output logic [DATA_W-1:0]   rd_data_b,
    output logic                rd_valid_a,
    output logic                rd_valid_b,
    output logic                err,
    output logic [7:0]          err_cnt
);

    localparam int NB = DATA_W / 8;
    localparam logic [ADDR_W:0] LIMIT = (ADDR_W + 1)'(NUM_REGS);

    logic [DATA_W-1:0] regs [NUM_REGS];

    logic              wr_ok;
    logic              ok_a;
    logic              ok_b;
    logic              wr_go;
    logic [DATA_W-1:0] cur_w;
    logic [DATA_W-1:0] raw_a;
    logic [DATA_W-1:0] raw_b;
    logic [DATA_W-1:0] merged;
    logic [DATA_W-1:0] nxt_a;
    logic [DATA_W-1:0] nxt_b;
    logic [1:0]        e_cnt;
    logic [8:0]        sum;

    assign wr_ok = {1'b0, wr_addr} < LIMIT;
    assign ok_a  = {1'b0, rd_addr_a} < LIMIT;
    assign ok_b  = {1'b0, rd_addr_b} < LIMIT;

    // Explicit decode loop keeps every index in range for any NUM_REGS.
    always_comb begin
        cur_w = '0;
        raw_a = '0;
        raw_b = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (wr_addr == ADDR_W'(i))
                cur_w = regs[i];
            if (rd_addr_a == ADDR_W'(i))
                raw_a = regs[i];
            if (rd_addr_b == ADDR_W'(i))
                raw_b = regs[i];
        end
    end

    always_comb begin
        merged = cur_w;
        for (int k = 0; k < NB; k++) begin
            if (wr_be[k])
                merged[8*k +: 8] = wr_data[8*k +: 8];
        end
    end

    // A clear wins over a write; an all-zero byte mask is a no-op.
    assign wr_go = wr_en & wr_ok & (|wr_be) & ~clr;

    // Read results reflect the state committed on this same edge.
    always_comb begin
        if (!ok_a || clr)
            nxt_a = '0;
        else if (wr_go && rd_addr_a == wr_addr)
            nxt_a = merged;
        else
            nxt_a = raw_a;
    end

    always_comb begin
        if (!ok_b || clr)
            nxt_b = '0;
        else if (wr_go && rd_addr_b == wr_addr)
            nxt_b = merged;
        else
            nxt_b = raw_b;
    end

    // Invalid writes count regardless of clr or byte mask.
    assign e_cnt = {1'b0, wr_en & ~wr_ok}
                 + {1'b0, rd_en_a & ~ok_a}
                 + {1'b0, rd_en_b & ~ok_b};

    assign sum = {1'b0, err_cnt} + {7'b0, e_cnt};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= '0;
            rd_data_a  <= '0;
            rd_data_b  <= '0;
            rd_valid_a <= 1'b0;
            rd_valid_b <= 1'b0;
            err        <= 1'b0;
            err_cnt    <= 8'd0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (clr)
                    regs[i] <= '0;
                else if (wr_go && wr_addr == ADDR_W'(i))
                    regs[i] <= merged;
            end
            rd_valid_a <= rd_en_a;
            rd_valid_b <= rd_en_b;
            if (rd_en_a)
                rd_data_a <= nxt_a;
            if (rd_en_b)
                rd_data_b <= nxt_b;
            err     <= |e_cnt;
            err_cnt <= sum[8] ? 8'hFF : sum[7:0];
        end
    end

endmodule

// File: tb/tb_reg_bank_multi.sv
// tb_reg_bank_multi: directed and randomized checks of reg_bank_multi
// against a behavioural register-bank model.
module tb_reg_bank_multi;

    localparam int NR = 14;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_addr = '0;
    logic [15:0] wr_data = '0;
    logic [1:0]  wr_be = '0;
    logic        clr = 1'b0;
    logic        rd_en_a = 1'b0;
    logic [3:0]  rd_addr_a = '0;
    logic        rd_en_b = 1'b0;
    logic [3:0]  rd_addr_b = '0;
    logic [15:0] rd_data_a;
    logic [15:0] rd_data_b;
    logic        rd_valid_a;
    logic        rd_valid_b;
    logic        err;
    logic [7:0]  err_cnt;

    int total = 0;
    int bad   = 0;
    bit model_on = 1'b0;

    int m_mem [NR];
    int m_rda, m_rdb, m_cnt;
    bit m_va, m_vb, m_err;

    reg_bank_multi dut (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_be(wr_be),
        .clr(clr),
        .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a),
        .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b),
        .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
        .rd_valid_a(rd_valid_a), .rd_valid_b(rd_valid_b),
        .err(err), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Model: apply write, then clear, then read the resulting bank.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            foreach (m_mem[i]) m_mem[i] = 0;
            m_rda = 0; m_rdb = 0; m_cnt = 0;
            m_va = 0; m_vb = 0; m_err = 0;
        end else begin
            int e;
            e = 0;
            if (wr_en && wr_addr >= NR) e++;
            if (rd_en_a && rd_addr_a >= NR) e++;
            if (rd_en_b && rd_addr_b >= NR) e++;
            if (wr_en && wr_addr < NR) begin
                int v;
                v = m_mem[wr_addr];
                if (wr_be[0]) v = (v / 256) * 256 + wr_data % 256;
                if (wr_be[1]) v = (wr_data / 256) * 256 + v % 256;
                m_mem[wr_addr] = v;
            end
            if (clr) foreach (m_mem[i]) m_mem[i] = 0;
            m_va = rd_en_a;
            m_vb = rd_en_b;
            if (rd_en_a) m_rda = (rd_addr_a < NR) ? m_mem[rd_addr_a] : 0;
            if (rd_en_b) m_rdb = (rd_addr_b < NR) ? m_mem[rd_addr_b] : 0;
            m_err = (e > 0);
            m_cnt = (m_cnt + e > 255) ? 255 : m_cnt + e;
        end
    end

    always @(negedge clk) begin
        if (model_on && !rst) begin
            chk("rd_data_a", rd_data_a, m_rda);
            chk("rd_data_b", rd_data_b, m_rdb);
            chk("rd_valid_a", rd_valid_a, m_va);
            chk("rd_valid_b", rd_valid_b, m_vb);
            chk("err", err, m_err);
            chk("err_cnt", err_cnt, m_cnt);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en = 0; clr = 0; rd_en_a = 0; rd_en_b = 0; wr_be = 0;
    endtask

    task automatic wr(input int a, input int d, input int be);
        wr_en = 1; wr_addr = 4'(a); wr_data = 16'(d); wr_be = 2'(be);
    endtask

    task automatic pulse_rst();
        rst = 1; cyc(); cyc(); rst = 0;
    endtask

    initial begin
        int cnt_before;
        idle();
        cyc();
        pulse_rst();
        model_on = 1;

        // reset state: all registers read zero
        for (int a = 0; a < NR; a++) begin
            rd_en_a = 1; rd_addr_a = 4'(a);
            cyc();
            chk("t1_data", rd_data_a, 16'h0000);
            chk("t1_valid", rd_valid_a, 1);
        end
        idle();
        cyc();
        chk("t1_cnt", err_cnt, 0);

        // byte enables
        wr(3, 16'h1234, 2'b11); cyc();
        wr(3, 16'hABCD, 2'b10); cyc();
        idle(); rd_en_a = 1; rd_addr_a = 3; cyc();
        chk("t2_merge", rd_data_a, 16'hAB34);

        // invalid write and dual invalid read
        idle(); wr(14, 16'hDEAD, 2'b11); cyc();
        idle();
        rd_en_a = 1; rd_addr_a = 14; rd_en_b = 1; rd_addr_b = 15;
        cyc();
        chk("t3_da", rd_data_a, 0);
        chk("t3_db", rd_data_b, 0);
        chk("t3_va", rd_valid_a, 1);
        chk("t3_vb", rd_valid_b, 1);
        chk("t3_err", err, 1);
        chk("t3_cnt", err_cnt, 3);

        // write-first forwarding on both ports
        idle(); wr(5, 16'h0001, 2'b11); cyc();
        wr(5, 16'hBEEF, 2'b11);
        rd_en_a = 1; rd_addr_a = 5; rd_en_b = 1; rd_addr_b = 5;
        cyc();
        chk("t4_a", rd_data_a, 16'hBEEF);
        chk("t4_b", rd_data_b, 16'hBEEF);

        // clear beats a same-cycle write
        idle(); cyc();
        cnt_before = err_cnt;
        clr = 1; wr(0, 16'h5555, 2'b11); cyc();
        idle();
        for (int a = 0; a < NR; a++) begin
            rd_en_a = 1; rd_addr_a = 4'(a);
            rd_en_b = 1; rd_addr_b = 4'(NR - 1 - a);
            cyc();
            chk("t5_a", rd_data_a, 0);
            chk("t5_b", rd_data_b, 0);
        end
        chk("t5_cnt", err_cnt, cnt_before);

        // randomized traffic, occasional clear and async reset
        for (int n = 0; n < 3000; n++) begin
            wr_en     = ($urandom_range(0, 2) != 0);
            wr_addr   = 4'($urandom_range(0, 15));
            wr_data   = 16'($urandom);
            wr_be     = 2'($urandom_range(0, 3));
            clr       = ($urandom_range(0, 31) == 0);
            rd_en_a   = ($urandom_range(0, 1) != 0);
            rd_addr_a = ($urandom_range(0, 1) != 0) ? wr_addr
                                                    : 4'($urandom_range(0, 15));
            rd_en_b   = ($urandom_range(0, 1) != 0);
            rd_addr_b = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 499) == 0) begin
                #2 rst = 1;
                #1 rst = 0;
            end
            cyc();
        end
        idle();
        cyc();

        // saturation, then reset between edges
        pulse_rst();
        rd_en_a = 1; rd_addr_a = 15;
        for (int n = 0; n < 300; n++) cyc();
        chk("t6_sat", err_cnt, 255);
        idle();
        #2 rst = 1;
        #1;
        chk("t6_cnt", err_cnt, 0);
        chk("t6_va", rd_valid_a, 0);
        chk("t6_vb", rd_valid_b, 0);
        chk("t6_data", rd_data_a, 0);
        cyc();
        rst = 0;
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
